// File: rtl/mii_xmit.sv
// MII transmit framer: wraps a byte-stream Ethernet frame (DA..payload) with
// preamble, SFD, zero pad and CRC-32 FCS, drives it out as nibbles low-first,
// then holds the line idle for the inter-frame gap. All outputs registered.
module mii_xmit #(
  parameter int PREAMBLE_BYTES = 7,
  parameter int MIN_FRAME      = 60,
  parameter int IFG_NIBBLES    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [3:0] txd,
  output logic       tx_en,
  output logic       tx_er,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, ABORT, IFG} state_t;

  state_t      state, state_n;
  logic        hi, hi_n;                 // high nibble of the current byte is on txd
  logic [7:0]  nib, nib_n;               // nibble counter for PRE / FCS / IFG
  logic [10:0] cnt, cnt_n;               // bytes sent (data + pad), saturating
  logic [31:0] crc, crc_n;               // running CRC; shifted out during FCS
  logic [7:0]  cur, cur_n;               // byte being transmitted
  logic        cur_last, cur_last_n;
  logic [3:0]  txd_n;
  logic        tx_en_n, tx_er_n, s_ready_n, underrun_n;

  // Reflected CRC-32 (poly 0x04C11DB7) advanced by one byte, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Byte counter increment that sticks at its maximum.
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  // Next-state and next-output decode; outputs describe the coming nibble.
  always_comb begin
    state_n    = state;
    hi_n       = hi;
    nib_n      = nib;
    cnt_n      = cnt;
    crc_n      = crc;
    cur_n      = cur;
    cur_last_n = cur_last;
    txd_n      = 4'h0;
    tx_en_n    = 1'b0;
    tx_er_n    = 1'b0;
    s_ready_n  = 1'b0;
    underrun_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_valid) begin
          state_n = PRE;
          nib_n   = 8'd0;
          cnt_n   = 11'd0;
          crc_n   = 32'hFFFFFFFF;
          txd_n   = 4'h5;
          tx_en_n = 1'b1;
        end
      end
      PRE: begin
        txd_n   = 4'h5;
        tx_en_n = 1'b1;
        if (nib >= 8'(2 * PREAMBLE_BYTES - 1)) begin
          state_n = SFD;
          hi_n    = 1'b0;
        end else begin
          nib_n = nib + 8'd1;
        end
      end
      SFD, DATA, PAD: begin
        tx_en_n = 1'b1;
        if (!hi) begin
          // Second nibble of the byte; fetch the next byte while it is on the wire.
          hi_n = 1'b1;
          if (state == SFD) begin
            txd_n     = 4'hD;
            s_ready_n = 1'b1;
          end else if (state == DATA) begin
            txd_n     = cur[7:4];
            s_ready_n = !cur_last;
          end
        end else if (state == SFD || (state == DATA && !cur_last)) begin
          if (s_valid) begin
            state_n    = DATA;
            hi_n       = 1'b0;
            cur_n      = s_data;
            cur_last_n = s_last;
            txd_n      = s_data[3:0];
            crc_n      = crc_byte(crc, s_data);
            cnt_n      = sat_inc(cnt);
          end else begin
            // Source starved while we were asking for a byte: poison the frame.
            state_n    = ABORT;
            txd_n      = 4'h0;
            tx_er_n    = 1'b1;
            underrun_n = 1'b1;
            s_ready_n  = 1'b1;
          end
        end else if (cnt < 11'(MIN_FRAME)) begin
          state_n = PAD;
          hi_n    = 1'b0;
          txd_n   = 4'h0;
          crc_n   = crc_byte(crc, 8'h00);
          cnt_n   = sat_inc(cnt);
        end else begin
          state_n = FCS;
          nib_n   = 8'd0;
          txd_n   = ~crc[3:0];
          crc_n   = {4'h0, crc[31:4]};
        end
      end
      FCS: begin
        if (nib == 8'd7) begin
          state_n = IFG;
          nib_n   = 8'd0;
        end else begin
          nib_n   = nib + 8'd1;
          tx_en_n = 1'b1;
          txd_n   = ~crc[3:0];
          crc_n   = {4'h0, crc[31:4]};
        end
      end
      ABORT: begin
        // Swallow the rest of the aborted frame up to and including s_last.
        s_ready_n = 1'b1;
        if (s_valid && s_last) begin
          state_n   = IFG;
          nib_n     = 8'd0;
          s_ready_n = 1'b0;
        end
      end
      IFG: begin
        // One gap cycle is spent in IDLE, so IFG itself is one cycle short.
        if (nib >= 8'(IFG_NIBBLES - 2)) state_n = IDLE;
        else                            nib_n   = nib + 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hi       <= 1'b0;
      nib      <= 8'd0;
      cnt      <= 11'd0;
      crc      <= 32'hFFFFFFFF;
      cur_last <= 1'b0;
      txd      <= 4'h0;
      tx_en    <= 1'b0;
      tx_er    <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state    <= state_n;
      hi       <= hi_n;
      nib      <= nib_n;
      cnt      <= cnt_n;
      crc      <= crc_n;
      cur_last <= cur_last_n;
      txd      <= txd_n;
      tx_en    <= tx_en_n;
      tx_er    <= tx_er_n;
      s_ready  <= s_ready_n;
      busy     <= (state_n != IDLE);
      underrun <= underrun_n;
    end
  end

  // Current byte holding register (pure data, no reset needed).
  always_ff @(posedge clk) begin
    cur <= cur_n;
  end

endmodule

// File: tb/tb_mii_xmit.sv
// Testbench for mii_xmit: records the MII lines every cycle, splits the record
// into tx_en bursts and compares each burst with a frame built from the byte
// list by a table-driven CRC-32 reference.
module tb_mii_xmit;
  localparam int PB = 7, MINF = 60, IFGN = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0, s_last = 1'b0;
  logic       s_ready, tx_en, tx_er, busy, underrun;
  logic [3:0] txd;

  mii_xmit #(.PREAMBLE_BYTES(PB), .MIN_FRAME(MINF), .IFG_NIBBLES(IFGN)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .txd(txd), .tx_en(tx_en), .tx_er(tx_er), .busy(busy),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle record of the DUT outputs, sampled on the falling edge.
  logic       rec = 1'b0;
  logic       tr_en[$], tr_er[$], tr_rdy[$], tr_un[$];
  logic [3:0] tr_d[$];

  always @(negedge clk) begin
    if (rec) begin
      tr_en.push_back(tx_en);
      tr_er.push_back(tx_er);
      tr_rdy.push_back(s_ready);
      tr_un.push_back(underrun);
      tr_d.push_back(txd);
    end
  end

  task automatic clear_trace();
    tr_en.delete(); tr_er.delete(); tr_rdy.delete(); tr_un.delete(); tr_d.delete();
  endtask

  // tx_en bursts found in the record: start index and length.
  int fs[$], fl[$];

  task automatic scan();
    fs.delete(); fl.delete();
    for (int i = 0; i < tr_en.size(); i++) begin
      if (tr_en[i] === 1'b1 && (i == 0 || tr_en[i-1] !== 1'b1)) begin
        int j;
        j = i;
        while (j < tr_en.size() && tr_en[j] === 1'b1) j++;
        fs.push_back(i);
        fl.push_back(j - i);
      end
    end
  endtask

  // Reference frame builder.
  logic [31:0] crc_tab[256];
  logic [7:0]  frm[$];
  logic [3:0]  exp_q[$];

  task automatic build_tab();
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tab[n] = c;
    end
  endtask

  task automatic model();
    logic [7:0]  body[$];
    logic [31:0] c, f;
    exp_q.delete();
    body = frm;
    while (body.size() < MINF) body.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (body[i]) c = crc_tab[c[7:0] ^ body[i]] ^ (c >> 8);
    f = ~c;
    for (int k = 0; k < 4; k++) body.push_back(f[8*k +: 8]);
    for (int i = 0; i < 2 * PB + 1; i++) exp_q.push_back(4'h5);
    exp_q.push_back(4'hD);
    foreach (body[i]) begin
      exp_q.push_back(body[i][3:0]);
      exp_q.push_back(body[i][7:4]);
    end
  endtask

  task automatic rand_frame(input int n);
    frm.delete();
    repeat (n) frm.push_back(8'($urandom));
  endtask

  // Offer frm on the byte stream; optionally starve once at byte drop_at or
  // raise reset when byte rst_at is next. Leaves the last byte being offered.
  task automatic send(input int drop_at, input int rst_at);
    int  i, guard;
    bit  dropped;
    i = 0; guard = 0; dropped = 0;
    while (i < frm.size()) begin
      @(negedge clk);
      guard++;
      if (guard > 4000) begin
        check("send handshake timeout", i, frm.size());
        return;
      end
      if (i == rst_at) begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      if (i == drop_at && !dropped && s_ready) begin
        s_valid = 1'b0; s_last = 1'b0; dropped = 1;
      end else begin
        s_valid = 1'b1;
        s_data  = frm[i];
        s_last  = (i == frm.size() - 1);
        if (s_ready) i++;
      end
    end
  endtask

  task automatic finish_frame();
    int guard;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    guard = 0;
    while (busy === 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("return to idle", busy, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic cmp_frame(input string name, input int k, input int cycles);
    int bad, ers;
    bad = -1; ers = 0;
    if (k >= fs.size()) begin
      check({name, " burst count"}, fs.size(), k + 1);
      return;
    end
    check({name, " nibbles"}, fl[k], exp_q.size());
    check({name, " tx_en cycles"}, fl[k], cycles);
    for (int i = 0; i < fl[k] && i < exp_q.size(); i++) begin
      if (bad < 0 && tr_d[fs[k] + i] !== exp_q[i]) bad = i;
      if (tr_er[fs[k] + i] !== 1'b0) ers++;
    end
    check({name, " first wrong nibble index"}, bad, -1);
    check({name, " tx_er nibbles"}, ers, 0);
  endtask

  typedef struct { int len; int cycles; } vec_t;
  vec_t vec[7];

  logic [7:0] qa[$], qb[$];
  logic [3:0] ea[$];

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int bad, cnt, gap;
    build_tab();
    vec[0] = '{len: 1,   cycles: 144};
    vec[1] = '{len: 14,  cycles: 144};
    vec[2] = '{len: 59,  cycles: 144};
    vec[3] = '{len: 60,  cycles: 144};
    vec[4] = '{len: 61,  cycles: 146};
    vec[5] = '{len: 64,  cycles: 152};
    vec[6] = '{len: 100, cycles: 224};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset txd", txd, 4'h0);
    check("reset tx_en", tx_en, 1'b0);
    check("reset tx_er", tx_er, 1'b0);
    check("reset s_ready", s_ready, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset underrun", underrun, 1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 64-byte broadcast frame with fixed header
    frm.delete();
    repeat (6) frm.push_back(8'hFF);
    frm.push_back(8'h02); repeat (4) frm.push_back(8'h00); frm.push_back(8'h01);
    frm.push_back(8'h08); frm.push_back(8'h00);
    for (int i = 0; i < 50; i++) frm.push_back(8'(i * 7 + 3));
    clear_trace(); rec = 1'b1;
    send(-1, -1); finish_frame(); rec = 1'b0;
    scan(); model();
    check("t1 burst count", fs.size(), 1);
    cmp_frame("t1", 0, 152);

    // Length table: padding boundaries and long frames
    for (int v = 0; v < 7; v++) begin
      rand_frame(vec[v].len);
      clear_trace(); rec = 1'b1;
      send(-1, -1); finish_frame(); rec = 1'b0;
      scan(); model();
      cmp_frame($sformatf("len%0d", vec[v].len), 0, vec[v].cycles);
    end

    // Back-to-back frames with s_valid held high
    rand_frame(64); qa = frm;
    rand_frame(64); qb = frm;
    clear_trace(); rec = 1'b1;
    frm = qa; send(-1, -1);
    frm = qb; send(-1, -1);
    finish_frame(); rec = 1'b0;
    scan();
    check("b2b burst count", fs.size(), 2);
    frm = qa; model(); cmp_frame("b2b first", 0, 152);
    frm = qb; model(); cmp_frame("b2b second", 1, 152);
    if (fs.size() >= 2) begin
      gap = fs[1] - (fs[0] + fl[0]);
      check("b2b idle gap", gap, IFGN);
      cnt = 0;
      for (int i = fs[0] + fl[0]; i < fs[1]; i++) if (tr_rdy[i] !== 1'b0) cnt++;
      check("b2b s_ready during gap", cnt, 0);
    end

    // Underrun at byte 20, then a normal frame
    rand_frame(40); qa = frm;
    clear_trace(); rec = 1'b1;
    send(20, -1); finish_frame();
    rand_frame(30); qb = frm;
    send(-1, -1); finish_frame(); rec = 1'b0;
    scan();
    check("underrun burst count", fs.size(), 2);
    frm = qa; model(); ea = exp_q;
    if (fs.size() >= 1) begin
      check("underrun burst len", fl[0], 16 + 40 + 1);
      bad = -1;
      for (int i = 0; i < 56 && i < fl[0]; i++) if (bad < 0 && tr_d[fs[0] + i] !== ea[i]) bad = i;
      check("underrun first wrong nibble index", bad, -1);
      cnt = 0;
      for (int i = 0; i < fl[0]; i++) if (tr_er[fs[0] + i] === 1'b1) cnt++;
      check("underrun tx_er nibbles", cnt, 1);
      check("underrun tx_er position", tr_er[fs[0] + fl[0] - 1], 1'b1);
      check("underrun error nibble txd", tr_d[fs[0] + fl[0] - 1], 4'h0);
      cnt = 0; bad = -1;
      for (int i = 0; i < tr_un.size(); i++) if (tr_un[i] === 1'b1) begin cnt++; bad = i; end
      check("underrun pulses", cnt, 1);
      check("underrun pulse cycle", bad, fs[0] + fl[0] - 1);
    end
    frm = qb; model(); cmp_frame("after underrun", 1, 144);

    // Reset in the middle of a frame
    rand_frame(64);
    send(-1, 30);
    @(negedge clk);
    check("mid reset tx_en", tx_en, 1'b0);
    check("mid reset tx_er", tx_er, 1'b0);
    check("mid reset s_ready", s_ready, 1'b0);
    check("mid reset busy", busy, 1'b0);
    check("mid reset txd", txd, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    rand_frame(20);
    clear_trace(); rec = 1'b1;
    send(-1, -1); finish_frame(); rec = 1'b0;
    scan(); model();
    check("after reset burst count", fs.size(), 1);
    cmp_frame("after reset", 0, 144);

    // Randomized frames against the reference
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(90, 1);
      rand_frame(n);
      repeat ($urandom_range(4, 0)) @(negedge clk);
      clear_trace(); rec = 1'b1;
      send(-1, -1); finish_frame(); rec = 1'b0;
      scan(); model();
      cmp_frame($sformatf("rand%0d len%0d", r, n), 0, 16 + 2 * ((n < MINF) ? MINF : n) + 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
